// File: rtl/ieee754_add_arbiter_pkg.sv
// Shared constants, requester ID encodings and the result payload type.
package ieee754_add_arbiter_pkg;

  localparam int unsigned FP_W     = 32;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned MANT_W   = FRAC_W + 1;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  typedef struct packed {
    logic [FP_W-1:0] data;
    logic            id;
    logic            sign_err;
  } res_t;

endpackage

// File: rtl/ieee754_add_arbiter_rr.sv
// Two-way round-robin arbiter: combinational grant plus the priority register.
// Ports: clk, rst (sync, active high); valid0/valid1 requests; can_accept from
// the output stage; grant0_c/grant1_c combinational grants.
module rr_arbiter2 #(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic can_accept,
  output logic grant0_c,
  output logic grant1_c
);

  logic prio_q, prio_d;

  // Grant and priority update; priority only moves on an actual accept.
  always_comb begin
    grant0_c = valid0 & (~valid1 | ~prio_q);
    grant1_c = valid1 & (~valid0 | prio_q);
    prio_d   = prio_q;
    if (can_accept & grant0_c) begin
      prio_d = 1'b1;
    end else if (can_accept & grant1_c) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) prio_q <= PRIO_INIT;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/ieee754_adder.sv
// Combinational single-precision adder for positive operands.
// Sign bits are ignored, the aligned smaller operand is truncated (no rounding),
// and NaN/Inf are not handled.
// Ports: a, b operands; sum_c = |a| + |b| (sign bit always 0).
module ieee754_adder
  import ieee754_add_arbiter_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] sum_c
);

  logic [EXP_W-1:0]  ea, eb, e_big, e_small, e_diff, e_res;
  logic [MANT_W-1:0] ma, mb, m_big, m_small, m_shift;
  logic [MANT_W:0]   m_sum;
  logic [FRAC_W-1:0] f_res;

  always_comb begin
    // Zero/denormal operands carry no hidden bit and sit at effective exponent 1.
    ea = (a[FP_W-2:FRAC_W] == '0) ? EXP_W'(1) : a[FP_W-2:FRAC_W];
    eb = (b[FP_W-2:FRAC_W] == '0) ? EXP_W'(1) : b[FP_W-2:FRAC_W];
    ma = {|a[FP_W-2:FRAC_W], a[FRAC_W-1:0]};
    mb = {|b[FP_W-2:FRAC_W], b[FRAC_W-1:0]};
    if (ea >= eb) begin
      e_big = ea; e_small = eb; m_big = ma; m_small = mb;
    end else begin
      e_big = eb; e_small = ea; m_big = mb; m_small = ma;
    end
    e_diff  = e_big - e_small;
    m_shift = m_small >> e_diff;
    m_sum   = {1'b0, m_big} + {1'b0, m_shift};
    if (m_sum[MANT_W]) begin
      e_res = e_big + EXP_W'(1);
      f_res = m_sum[FRAC_W:1];
    end else begin
      // Without a hidden bit the sum is denormal and encodes with exponent 0.
      e_res = m_sum[FRAC_W] ? e_big : '0;
      f_res = m_sum[FRAC_W-1:0];
    end
    sum_c = {1'b0, e_res, f_res};
  end

endmodule

// File: rtl/ieee754_add_arbiter.sv
// Shares one ieee754_adder between two valid/ready requesters with round-robin
// arbitration; the sum is registered with a requester ID and a sign flag, and
// output handshakes are counted.
// Ports: clk, rst (sync, active high); req{0,1}_valid/_ready/_a/_b requester
// handshakes; res_valid/res_ready/res_data/res_id/res_sign_err result
// handshake; op_count wrapping count of output handshakes.
module ieee754_add_arbiter
  import ieee754_add_arbiter_pkg::*;
#(
  parameter logic        PRIO_INIT = 1'b0,
  parameter int unsigned COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [FP_W-1:0]    req0_a,
  input  logic [FP_W-1:0]    req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [FP_W-1:0]    req1_a,
  input  logic [FP_W-1:0]    req1_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [FP_W-1:0]    res_data,
  output logic               res_id,
  output logic               res_sign_err,
  output logic [COUNT_W-1:0] op_count
);

  logic               can_accept_c, grant0_c, grant1_c;
  logic [FP_W-1:0]    op_a_c, op_b_c, sum_c;
  res_t               res_q, res_d;
  logic               res_valid_q, res_valid_d;
  logic [COUNT_W-1:0] op_count_q, op_count_d;

  // The output register may be refilled in the same cycle it drains.
  assign can_accept_c = ~res_valid_q | res_ready;

  rr_arbiter2 #(.PRIO_INIT(PRIO_INIT)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .can_accept (can_accept_c),
    .grant0_c   (grant0_c),
    .grant1_c   (grant1_c)
  );

  assign req0_ready = grant0_c & can_accept_c;
  assign req1_ready = grant1_c & can_accept_c;

  assign op_a_c = grant1_c ? req1_a : req0_a;
  assign op_b_c = grant1_c ? req1_b : req0_b;

  ieee754_adder u_add (
    .a     (op_a_c),
    .b     (op_b_c),
    .sum_c (sum_c)
  );

  // Output register and counter next state.
  always_comb begin
    res_d       = res_q;
    res_valid_d = res_valid_q;
    op_count_d  = op_count_q;
    if (res_valid_q & res_ready) begin
      res_valid_d = 1'b0;
      op_count_d  = op_count_q + COUNT_W'(1);
    end
    if (req0_ready | req1_ready) begin
      res_valid_d    = 1'b1;
      res_d.data     = sum_c;
      res_d.id       = req1_ready ? ID_REQ1 : ID_REQ0;
      res_d.sign_err = op_a_c[SIGN_BIT] | op_b_c[SIGN_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q       <= '0;
      res_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign res_valid    = res_valid_q;
  assign res_data     = res_q.data;
  assign res_id       = res_q.id;
  assign res_sign_err = res_q.sign_err;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_ieee754_add_arbiter.sv
module tb_ieee754_add_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        res_valid, res_ready, res_id, res_sign_err;
  logic [31:0] res_data;
  logic [15:0] op_count;

  int ncmp = 0;
  int nerr = 0;

  // Reference state: what the result port should show, in spec terms.
  logic        m_valid, m_id, m_sign, m_prio;
  logic [31:0] m_data;
  logic [15:0] m_count;
  logic        acc0_last, acc1_last;

  always #5 clk = ~clk;

  ieee754_add_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_sign_err(res_sign_err), .op_count(op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact real arithmetic on magnitudes, then truncation to 24 significant bits.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    d = {1'b0, 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] d;
    d = $realtobits(f2r(a) + f2r(b));
    return {1'b0, 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] f;
    f = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
    return f;
  endfunction

  // One clock cycle: drive at negedge, check, advance the reference across the edge.
  task automatic step(input logic r, input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic rr);
    logic g0, g1, can, hs;
    rst = r; req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1; res_ready = rr;
    #1;
    can = !m_valid || rr;
    g0  = v0 && (!v1 || !m_prio);
    g1  = v1 && (!v0 || m_prio);
    chk("req0_ready", 32'(req0_ready), 32'(g0 && can));
    chk("req1_ready", 32'(req1_ready), 32'(g1 && can));
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    chk("op_count", 32'(op_count), 32'(m_count));
    if (m_valid) begin
      chk("res_data", res_data, m_data);
      chk("res_id", 32'(res_id), 32'(m_id));
      chk("res_sign_err", 32'(res_sign_err), 32'(m_sign));
    end
    acc0_last = !r && g0 && can;
    acc1_last = !r && g1 && can;
    if (r) begin
      m_valid = 0; m_data = 0; m_id = 0; m_sign = 0; m_count = 0; m_prio = 1'b0;
    end else begin
      hs = m_valid && rr;
      if (hs) m_count = m_count + 16'd1;
      if (acc0_last) begin
        m_valid = 1; m_data = ref_add(a0, b0); m_id = 0; m_sign = a0[31] | b0[31]; m_prio = 1;
      end else if (acc1_last) begin
        m_valid = 1; m_data = ref_add(a1, b1); m_id = 1; m_sign = a1[31] | b1[31]; m_prio = 0;
      end else if (hs) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic        p0v, p1v;
    logic [31:0] p0a, p0b, p1a, p1b;
    logic [15:0] c0;
    m_valid = 0; m_data = 0; m_id = 0; m_sign = 0; m_count = 0; m_prio = 0;
    rst = 1; req0_valid = 0; req1_valid = 0; res_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    chk("reset_res_data", res_data, 32'd0);
    chk("reset_res_id", 32'(res_id), 32'd0);
    chk("reset_sign_err", 32'(res_sign_err), 32'd0);
    chk("reset_op_count", 32'(op_count), 32'd0);

    // req0 only: 1.0 + 2.0
    step(0, 1, 32'h3F800000, 32'h40000000, 0, 0, 0, 1);
    chk("one_plus_two", res_data, 32'h40400000);
    chk("one_plus_two_id", 32'(res_id), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("count_after_hs", 32'(op_count), 32'd1);

    // Tie on the first cycle after reset: port 0 first, then port 1.
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h3FC00000, 32'h3FC00000, 1, 32'h3F000000, 32'h3F000000, 1);
    chk("tie_first", res_data, 32'h40400000);
    chk("tie_first_id", 32'(res_id), 32'd0);
    step(0, 0, 0, 0, 1, 32'h3F000000, 32'h3F000000, 1);
    chk("tie_second", res_data, 32'h3F800000);
    chk("tie_second_id", 32'(res_id), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    // Six back-to-back ops with both requesters always valid.
    c0 = op_count;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, rnd_fp(), rnd_fp(), 1, rnd_fp(), rnd_fp(), 1);
      chk("alt_id", 32'(res_id), 32'(i % 2));
      chk("alt_valid", 32'(res_valid), 32'd1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("six_ops", 32'(op_count - c0), 32'd6);

    // Back-pressure: result held, readies low; release accepts the pending request.
    step(0, 1, 32'h3F800000, 32'h3F800000, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h40000000, 32'h3F800000, 1, 32'h3F800000, 32'h3F800000, 0);
      chk("bp_data", res_data, 32'h40000000);
      chk("bp_id", 32'(res_id), 32'd0);
    end
    step(0, 1, 32'h40000000, 32'h3F800000, 1, 32'h3F800000, 32'h3F800000, 1);
    chk("bp_release_id", 32'(res_id), 32'd1);
    chk("bp_release_data", res_data, 32'h40000000);

    // Sign flag on requester 1.
    step(0, 0, 0, 0, 1, 32'hBF800000, 32'h3F800000, 1);
    chk("sign_err", 32'(res_sign_err), 32'd1);
    chk("sign_data", res_data, 32'h40000000);

    // Randomized traffic; requesters hold operands until accepted.
    p0v = 0; p1v = 0; p0a = 0; p0b = 0; p1a = 0; p1b = 0;
    for (int i = 0; i < 300; i++) begin
      if (!p0v && $urandom_range(0, 1) == 1) begin p0v = 1; p0a = rnd_fp(); p0b = rnd_fp(); end
      if (!p1v && $urandom_range(0, 1) == 1) begin p1v = 1; p1a = rnd_fp(); p1b = rnd_fp(); end
      step(0, p0v, p0a, p0b, p1v, p1a, p1b, 1'($urandom_range(0, 3) != 0));
      if (acc0_last) p0v = 0;
      if (acc1_last) p1v = 0;
    end

    // Reset with a result pending and both requesters waiting.
    step(0, 1, 32'h3F800000, 32'h3F800000, 0, 0, 0, 1);
    step(0, 1, 32'h3F800000, 32'h40000000, 1, 32'h40000000, 32'h40000000, 0);
    step(1, 1, 32'h3F800000, 32'h40000000, 1, 32'h40000000, 32'h40000000, 0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    step(0, 1, 32'h3F800000, 32'h40000000, 1, 32'h40000000, 32'h40000000, 1);
    chk("rst_tie_id", 32'(res_id), 32'd0);
    chk("rst_tie_data", res_data, 32'h40400000);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
